// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and simultaneous push/pop; used for the
// prefetch queue and for tracking addresses of in-flight requests.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             empty_s;
  logic             full_s;
  logic             pop_fire_s;
  logic             push_fire_s;

  // Handshake qualification: a push into a full queue is only legal alongside a pop.
  always_comb begin
    empty_s     = (count_r == {CW{1'b0}});
    full_s      = (count_r == CW'(DEPTH));
    pop_fire_s  = pop & ~empty_s;
    push_fire_s = push & (~full_s | pop_fire_s);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_fire_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_fire_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(push_fire_s) - CW'(pop_fire_s);
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push_fire_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches, buffers
// returned words and redirects when the retired instruction's next PC is not sequential.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset_n,
  output logic        IMEM_req_valid,
  input  logic        IMEM_req_ready,
  output logic [31:0] IMEM_req_addr,
  input  logic        IMEM_rsp_valid,
  input  logic [31:0] IMEM_rsp_data,
  output logic        FETCH_valid,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  input  logic        FETCH_accept,
  input  logic [31:0] new_PC,
  output logic        FETCH_misaligned
);

  localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_cnt_r;

  logic [31:0]   fetch_pc_nxt_s;
  logic [CW-1:0] inflight_nxt_s;
  logic [CW-1:0] drop_cnt_nxt_s;

  fetch_entry_t  q_head_s;
  fetch_entry_t  q_push_data_s;
  logic [CW-1:0] q_count_s;
  logic [31:0]   pcq_head_s;
  logic [CW-1:0] pcq_count_s;

  logic          q_empty_s;
  logic          accept_s;
  logic          redirect_s;
  logic          pop_s;
  logic          dropping_s;
  logic          push_s;
  logic          credit_s;
  logic          req_fire_s;
  logic [CW:0]   occupancy_s;

  // Accept / redirect decode and response routing.
  always_comb begin
    q_empty_s  = (q_count_s == {CW{1'b0}});
    accept_s   = FETCH_accept & ~q_empty_s;
    redirect_s = accept_s & (new_PC != (q_head_s.pc + 32'd4));
    pop_s      = accept_s & ~redirect_s;
    dropping_s = IMEM_rsp_valid & (drop_cnt_r != {CW{1'b0}});
    push_s     = IMEM_rsp_valid & ~dropping_s & ~redirect_s & (pcq_count_s != {CW{1'b0}});
  end

  // A sequential pop this cycle frees a slot, so it counts as credit for back-to-back fetch.
  always_comb begin
    occupancy_s    = {1'b0, inflight_r} + {1'b0, q_count_s} - (CW + 1)'(pop_s);
    credit_s       = (occupancy_s < (CW + 1)'(FIFO_DEPTH));
    IMEM_req_valid = SYS_reset_n & credit_s & (drop_cnt_r == {CW{1'b0}}) & ~redirect_s;
    IMEM_req_addr  = fetch_pc_r;
    req_fire_s     = IMEM_req_valid & IMEM_req_ready;
  end

  // Next-state for fetch pointer and outstanding-request bookkeeping.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    inflight_nxt_s = inflight_r;
    drop_cnt_nxt_s = drop_cnt_r;
    if (redirect_s) begin
      inflight_nxt_s = inflight_r - CW'(IMEM_rsp_valid);
      drop_cnt_nxt_s = inflight_r - CW'(IMEM_rsp_valid);
      fetch_pc_nxt_s = {new_PC[31:2], 2'b00};
    end else begin
      inflight_nxt_s = inflight_r + CW'(req_fire_s) - CW'(IMEM_rsp_valid);
      drop_cnt_nxt_s = drop_cnt_r - CW'(dropping_s);
      if (req_fire_s) begin
        fetch_pc_nxt_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
    end
  end

  // Fetch-state registers.
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      fetch_pc_r <= RESET_PC;
      inflight_r <= {CW{1'b0}};
      drop_cnt_r <= {CW{1'b0}};
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      inflight_r <= inflight_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  // Head presentation; an empty queue shows a NOP at the reset PC.
  always_comb begin
    FETCH_valid      = ~q_empty_s;
    FETCH_misaligned = accept_s & (new_PC[1:0] != 2'b00);
    if (q_empty_s) begin
      instruction = NOP_INSTR;
      PC          = RESET_PC;
    end else begin
      instruction = q_head_s.instr;
      PC          = q_head_s.pc;
    end
  end

  assign q_push_data_s = '{pc: pcq_head_s, instr: IMEM_rsp_data};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_prefetch_q (
    .clk       (SYS_clk),
    .rst_n     (SYS_reset_n),
    .flush     (redirect_s),
    .push      (push_s),
    .push_data (q_push_data_s),
    .pop       (pop_s),
    .head_data (q_head_s),
    .count     (q_count_s)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_inflight_pc_q (
    .clk       (SYS_clk),
    .rst_n     (SYS_reset_n),
    .flush     (redirect_s),
    .push      (req_fire_s),
    .push_data (fetch_pc_r),
    .pop       (push_s),
    .head_data (pcq_head_s),
    .count     (pcq_count_s)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a fixed-latency memory model returns
// address-tagged words and the expected (PC, instruction) stream is queued per retirement.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NEVER = 32'hFFFF_FFF0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        SYS_clk;
  logic        SYS_reset_n;
  logic        IMEM_req_valid;
  logic        IMEM_req_ready;
  logic [31:0] IMEM_req_addr;
  logic        IMEM_rsp_valid;
  logic [31:0] IMEM_rsp_data;
  logic        FETCH_valid;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic        FETCH_accept;
  logic [31:0] new_PC;
  logic        FETCH_misaligned;

  int n_checks = 0;
  int n_fail   = 0;
  int retired  = 0;
  int lat_idx  = 0;
  bit valid_cont = 1'b0;
  exp_t sb[$];
  logic [31:0] r_from0, r_to0, r_from1, r_to1;

  logic        vpipe [3];
  logic [31:0] apipe [3];

  inst_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .SYS_clk          (SYS_clk),
    .SYS_reset_n      (SYS_reset_n),
    .IMEM_req_valid   (IMEM_req_valid),
    .IMEM_req_ready   (IMEM_req_ready),
    .IMEM_req_addr    (IMEM_req_addr),
    .IMEM_rsp_valid   (IMEM_rsp_valid),
    .IMEM_rsp_data    (IMEM_rsp_data),
    .FETCH_valid      (FETCH_valid),
    .instruction      (instruction),
    .PC               (PC),
    .FETCH_accept     (FETCH_accept),
    .new_PC           (new_PC),
    .FETCH_misaligned (FETCH_misaligned)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] target(input logic [31:0] pc);
    if (pc == r_from0) return r_to0;
    else if (pc == r_from1) return r_to1;
    else return pc + 32'd4;
  endfunction

  // Fixed-latency in-order instruction memory, reset with the DUT.
  always @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      for (int i = 0; i < 3; i++) begin
        vpipe[i] <= 1'b0;
        apipe[i] <= 32'h0;
      end
    end else begin
      vpipe[0] <= IMEM_req_valid & IMEM_req_ready;
      apipe[0] <= IMEM_req_addr;
      for (int i = 1; i < 3; i++) begin
        vpipe[i] <= vpipe[i-1];
        apipe[i] <= apipe[i-1];
      end
    end
  end

  assign IMEM_rsp_valid = vpipe[lat_idx];
  assign IMEM_rsp_data  = mem_word(apipe[lat_idx]);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One data-path cycle: compare the head against the scoreboard and retire it if enabled.
  task automatic step(input bit acc_en);
    exp_t        e;
    logic [31:0] np;
    @(negedge SYS_clk);
    if (valid_cont) check_val("valid_cont", {31'b0, FETCH_valid}, 32'd1);
    if (FETCH_valid && acc_en) begin
      if (sb.size() == 0) begin
        check_val("sb_empty", 32'd1, 32'd0);
        FETCH_accept = 1'b0;
      end else begin
        e = sb.pop_front();
        check_val("pc", PC, e.pc);
        check_val("instr", instruction, e.instr);
        np = target(e.pc);
        FETCH_accept = 1'b1;
        new_PC = np;
        sb.push_back('{pc: np & ~32'd3, instr: mem_word(np & ~32'd3)});
        retired++;
        #1 check_val("misaligned", {31'b0, FETCH_misaligned}, {31'b0, (np[1:0] != 2'b00)});
      end
    end else begin
      FETCH_accept = 1'b0;
      new_PC = 32'h0;
      #1 check_val("misaligned_idle", {31'b0, FETCH_misaligned}, 32'd0);
      if (!FETCH_valid) check_val("nop_when_empty", instruction, NOP_INSTR);
    end
    @(posedge SYS_clk);
  endtask

  // Assert reset now, check the reset outputs, release on a falling edge.
  task automatic do_reset(input int lat);
    FETCH_accept = 1'b0;
    SYS_reset_n  = 1'b0;
    #1;
    check_val("rst_valid", {31'b0, FETCH_valid}, 32'd0);
    check_val("rst_instr", instruction, NOP_INSTR);
    check_val("rst_pc", PC, RPC);
    check_val("rst_req_valid", {31'b0, IMEM_req_valid}, 32'd0);
    check_val("rst_misaligned", {31'b0, FETCH_misaligned}, 32'd0);
    lat_idx = lat - 1;
    repeat (2) @(negedge SYS_clk);
    SYS_reset_n = 1'b1;
    sb.delete();
    sb.push_back('{pc: RPC, instr: mem_word(RPC)});
    #1;
    check_val("first_req_valid", {31'b0, IMEM_req_valid}, 32'd1);
    check_val("first_req_addr", IMEM_req_addr, RPC);
  endtask

  initial begin
    logic [31:0] held_addr;
    int          base;
    SYS_reset_n    = 1'b1;
    IMEM_req_ready = 1'b1;
    FETCH_accept   = 1'b0;
    new_PC         = 32'h0;
    r_from0 = NEVER; r_to0 = NEVER; r_from1 = NEVER; r_to1 = NEVER;
    #2;

    // Streaming with a 1-cycle memory: one instruction per cycle after the first.
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      valid_cont = (i >= 1);
      step(1'b1);
    end
    valid_cont = 1'b0;
    check_val("stream_retired", retired, 32'd11);

    // 3-cycle memory: redirect with responses in flight, then a misaligned target.
    r_from0 = 32'h0000_0008; r_to0 = 32'h0000_0040;
    r_from1 = 32'h0000_0048; r_to1 = 32'h0000_0102;
    do_reset(3);
    base = retired;
    for (int i = 0; i < 30; i++) step(1'b1);
    check_val("redirect_progress", {31'b0, (retired - base >= 12)}, 32'd1);

    // Data path stall: credit runs out, queue holds the entries.
    for (int i = 0; i < 6; i++) step(1'b0);
    @(negedge SYS_clk);
    check_val("stall_req_valid", {31'b0, IMEM_req_valid}, 32'd0);
    check_val("stall_fetch_valid", {31'b0, FETCH_valid}, 32'd1);

    // Memory not ready: address held while the queue drains.
    IMEM_req_ready = 1'b0;
    held_addr = IMEM_req_addr;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      #1 check_val("held_addr", IMEM_req_addr, held_addr);
    end
    IMEM_req_ready = 1'b1;
    base = retired;
    for (int i = 0; i < 20; i++) step(1'b1);
    check_val("resume_progress", {31'b0, (retired - base >= 12)}, 32'd1);

    // Reset in the middle of a full queue.
    r_from0 = NEVER; r_to0 = NEVER; r_from1 = NEVER; r_to1 = NEVER;
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 6; i++) step(1'b0);
    @(negedge SYS_clk);
    check_val("full_before_reset", {31'b0, FETCH_valid}, 32'd1);
    #2;
    do_reset(1);
    base = retired;
    for (int i = 0; i < 8; i++) step(1'b1);
    check_val("post_reset_progress", {31'b0, (retired - base >= 6)}, 32'd1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
